// File: rtl/mipscpu_pkg.sv
// =============================================================================
// Module : mipscpu_pkg
// Brief  : Shared opcode/funct constants, FSM state and ALU-control enums.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

package mipscpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEM       = 3'd3,
        WRITEBACK = 3'd4
    } state_t;

    typedef enum logic {
        ALU_ADD = 1'b0,
        ALU_SUB = 1'b1
    } alu_ctrl_t;

    function automatic logic [31:0] signext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

`default_nettype wire

// File: rtl/mipscpu_datamem.sv
// =============================================================================
// Module : datamem
// Brief  : Word-addressed data memory, combinational read, synchronous write.
//          Deliberately not reset so preloaded contents survive a CPU reset.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module datamem #(
    parameter int WORDS = 256,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] memory [0:WORDS-1];

    assign o_rdata = memory[i_addr];

    always_ff @(posedge clk) begin
        if (i_we) begin
            memory[i_addr] <= i_wdata;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mipscpu_regfile.sv
// =============================================================================
// Module : regfile
// Brief  : 32x32 register file, two combinational reads, one synchronous write;
//          $0 reads as zero and ignores writes.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  i_raddr1,
    input  logic [4:0]  i_raddr2,
    output logic [31:0] o_rdata1,
    output logic [31:0] o_rdata2,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata
);

    logic [31:0] register [0:31];

    assign o_rdata1 = (i_raddr1 == 5'd0) ? 32'd0 : register[i_raddr1];
    assign o_rdata2 = (i_raddr2 == 5'd0) ? 32'd0 : register[i_raddr2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                register[i] <= 32'd0;
            end
        end else if (i_we && (i_waddr != 5'd0)) begin
            register[i_waddr] <= i_wdata;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mipscpu.sv
// =============================================================================
// Module : mipscpu
// Brief  : Multi-cycle MIPS subset (lw, add, sub; sw when MIPSCPU_SW_EN is
//          defined) started by a rising edge on newinstr.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module mipscpu
    import mipscpu_pkg::*;
#(
    parameter int DMEM_WORDS = 256
) (
    input  logic        reset,
    input  logic        clock,
    input  logic [31:0] instrword,
    input  logic        newinstr
);

    localparam int c_AW = $clog2(DMEM_WORDS);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_ir;
    logic [31:0] r_aluout;
    logic [31:0] r_mdr;
    logic        r_newinstr_d;

    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [5:0]  w_funct;
    logic [31:0] w_rs_data;
    logic [31:0] w_rt_data;
    logic [31:0] w_mem_rdata;
    logic [31:0] w_alu_b;
    logic [31:0] w_alu_y;
    logic        w_start;
    logic        w_is_lw;
    logic        w_is_sw;
    logic        w_is_alu;
    alu_ctrl_t   w_alu_ctrl;
    logic        w_rf_we;
    logic        w_mem_we;
    logic        w_unused;

    assign w_op     = r_ir[31:26];
    assign w_rs     = r_ir[25:21];
    assign w_rt     = r_ir[20:16];
    assign w_rd     = r_ir[15:11];
    assign w_funct  = r_ir[5:0];
    assign w_unused = ^r_ir[10:6];

    assign w_start  = (r_state == IDLE) && newinstr && !r_newinstr_d;

    always_comb begin
        w_is_lw    = 1'b0;
        w_is_sw    = 1'b0;
        w_is_alu   = 1'b0;
        w_alu_ctrl = ALU_ADD;
        case (w_op)
            OP_LW: w_is_lw = 1'b1;
`ifdef MIPSCPU_SW_EN
            OP_SW: w_is_sw = 1'b1;
`endif
            OP_RTYPE: begin
                if (w_funct == FN_ADD) begin
                    w_is_alu = 1'b1;
                end else if (w_funct == FN_SUB) begin
                    w_is_alu   = 1'b1;
                    w_alu_ctrl = ALU_SUB;
                end
            end
            default: ;
        endcase
    end

    // Memory ops reuse the adder for the effective address.
    assign w_alu_b = w_is_alu ? w_rt_data : signext16(r_ir[15:0]);
    assign w_alu_y = (w_alu_ctrl == ALU_SUB) ? (w_rs_data - w_alu_b)
                                              : (w_rs_data + w_alu_b);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (w_start) w_next = DECODE;
            DECODE:    w_next = EXECUTE;
            EXECUTE:   w_next = (w_is_lw || w_is_sw) ? MEM : WRITEBACK;
            MEM:       w_next = w_is_lw ? WRITEBACK : IDLE;
            WRITEBACK: w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_newinstr_d <= 1'b0;
            r_ir         <= 32'd0;
            r_aluout     <= 32'd0;
            r_mdr        <= 32'd0;
        end else begin
            r_newinstr_d <= newinstr;
            if (w_start) begin
                r_ir <= instrword;
            end
            if (r_state == EXECUTE) begin
                r_aluout <= w_alu_y;
            end
            if (r_state == MEM) begin
                r_mdr <= w_mem_rdata;
            end
        end
    end

    assign w_rf_we  = (r_state == WRITEBACK) && (w_is_lw || w_is_alu);
    assign w_mem_we = (r_state == MEM) && w_is_sw;

    regfile myregisterfile (
        .clk      (clock),
        .rst      (reset),
        .i_raddr1 (w_rs),
        .i_raddr2 (w_rt),
        .o_rdata1 (w_rs_data),
        .o_rdata2 (w_rt_data),
        .i_we     (w_rf_we),
        .i_waddr  (w_is_lw ? w_rt : w_rd),
        .i_wdata  (w_is_lw ? r_mdr : r_aluout)
    );

    datamem #(
        .WORDS (DMEM_WORDS),
        .AW    (c_AW)
    ) mydatamem (
        .clk     (clock),
        .i_we    (w_mem_we),
        .i_addr  (r_aluout[c_AW-1:0]),
        .i_wdata (w_rt_data),
        .o_rdata (w_mem_rdata)
    );

endmodule

`default_nettype wire

// File: tb/tb_mipscpu.sv
// =============================================================================
// Module : tb_mipscpu
// Brief  : Directed and random checks of mipscpu against an ISA-level model.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module tb_mipscpu;
    import mipscpu_pkg::*;

    localparam int DMEM = 256;

    logic        reset;
    logic        clock;
    logic [31:0] instrword;
    logic        newinstr;

    int checks = 0;
    int errors = 0;

    logic [31:0] mreg [32];
    logic [31:0] mmem [DMEM];

    mipscpu #(.DMEM_WORDS(DMEM)) dut (
        .reset     (reset),
        .clock     (clock),
        .instrword (instrword),
        .newinstr  (newinstr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    // ISA-level reference: interprets the instruction word directly.
    function automatic void model_exec(input logic [31:0] ins);
        logic [5:0]  op;
        logic [5:0]  fn;
        int          rs, rt, rd;
        logic [31:0] ea;
        op = ins[31:26];
        fn = ins[5:0];
        rs = int'(ins[25:21]);
        rt = int'(ins[20:16]);
        rd = int'(ins[15:11]);
        ea = mreg[rs] + {{16{ins[15]}}, ins[15:0]};
        if (op == 6'b000000 && fn == 6'b100000) begin
            if (rd != 0) mreg[rd] = mreg[rs] + mreg[rt];
        end else if (op == 6'b000000 && fn == 6'b100010) begin
            if (rd != 0) mreg[rd] = mreg[rs] - mreg[rt];
        end else if (op == 6'b100011) begin
            if (rt != 0) mreg[rt] = mmem[ea % DMEM];
        end
`ifdef MIPSCPU_SW_EN
        else if (op == 6'b101011) begin
            mmem[ea % DMEM] = mreg[rt];
        end
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d (0x%08h) expected=%0d (0x%08h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic set_mem(input int a, input logic [31:0] v);
        dut.mydatamem.memory[a] = v;
        mmem[a] = v;
    endtask

    task automatic set_reg(input int r, input logic [31:0] v);
        if (r != 0) begin
            dut.myregisterfile.register[r] = v;
            mreg[r] = v;
        end
    endtask

    task automatic exec(input logic [31:0] ins, input int hold);
        @(negedge clock);
        instrword = ins;
        newinstr  = 1'b1;
        repeat (hold) @(negedge clock);
        newinstr = 1'b0;
        repeat (6) @(negedge clock);
        model_exec(ins);
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 32; i++) begin
            check($sformatf("%s_reg%0d", tag, i), dut.myregisterfile.register[i], mreg[i]);
        end
    endtask

    task automatic run_prog(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                            input logic [31:0] exp5, input logic [31:0] exp4, input string tag);
        set_mem(0, a);
        set_mem(1, b);
        set_mem(2, c);
        exec(enc_i(6'b100011, 0, 1, 16'd0), 1);
        exec(enc_i(6'b100011, 0, 2, 16'd1), 1);
        exec(enc_i(6'b100011, 0, 3, 16'd2), 1);
        exec(enc_r(1, 2, 5, 6'b100000), 1);
        exec(enc_r(5, 3, 4, 6'b100010), 1);
        check({tag, "_r1"}, dut.myregisterfile.register[1], a);
        check({tag, "_r2"}, dut.myregisterfile.register[2], b);
        check({tag, "_r3"}, dut.myregisterfile.register[3], c);
        check({tag, "_r5"}, dut.myregisterfile.register[5], exp5);
        check({tag, "_r4"}, dut.myregisterfile.register[4], exp4);
        check_regs(tag);
    endtask

    initial begin
        logic [31:0] ins;
        logic [31:0] mem5_before;
        int          kind;

        reset     = 1'b1;
        newinstr  = 1'b0;
        instrword = 32'd0;
        for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
        repeat (2) @(negedge clock);
        // Backdoor fill while reset is held; contents must survive it.
        for (int i = 0; i < DMEM; i++) set_mem(i, $urandom);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        check("reset_state", 32'(dut.r_state), 32'(IDLE));
        check("reset_ir", dut.r_ir, 32'd0);
        check_regs("reset");
        check("mem_persist_7", dut.mydatamem.memory[7], mmem[7]);
        check("mem_persist_200", dut.mydatamem.memory[200], mmem[200]);

        run_prog(32'd10, 32'd22, 32'd6, 32'd32, 32'd26, "prog_a");
        run_prog(32'd8, 32'd2, 32'd3, 32'd10, 32'd7, "prog_b");
        run_prog(32'd1024, 32'd2056, 32'd3000, 32'd3080, 32'd80, "prog_c");
        run_prog(32'd1000000000, 32'd2000000000, 32'd500000000,
                 32'd3000000000, 32'd2500000000, "prog_d");

        set_reg(1, 32'd1);
        set_reg(2, 32'd1);
        set_reg(5, 32'd0);
        exec(enc_r(1, 2, 5, 6'b100000), 5);
        check("hold_r5", dut.myregisterfile.register[5], 32'd2);
        exec(enc_r(1, 2, 1, 6'b100000), 5);
        check("hold_once_r1", dut.myregisterfile.register[1], 32'd2);

        exec(enc_r(1, 2, 0, 6'b100000), 1);
        check("r0_stays_zero", dut.myregisterfile.register[0], 32'd0);

        set_reg(1, 32'd77);
        set_mem(5, 32'd123);
        mem5_before = 32'd123;
        exec(enc_i(6'b101011, 0, 1, 16'd5), 1);
`ifdef MIPSCPU_SW_EN
        check("sw_mem5", dut.mydatamem.memory[5], 32'd77);
`else
        check("sw_mem5", dut.mydatamem.memory[5], mem5_before);
`endif
        check_regs("after_sw");

        // Random mix of supported and unsupported instructions.
        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 5));
            case (kind)
                0, 1: ins = enc_i(6'b100011, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 16'($urandom));
                2:    ins = enc_r(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 6'b100000);
                3:    ins = enc_r(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 6'b100010);
                4:    ins = enc_i(6'b101011, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 16'($urandom));
                default: ins = ($urandom_range(0, 1) == 0)
                             ? enc_i(6'b001000, int'($urandom_range(0, 31)), int'($urandom_range(1, 31)), 16'($urandom))
                             : enc_r(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(1, 31)), 6'b100100);
            endcase
            exec(ins, int'($urandom_range(1, 3)));
            check_regs($sformatf("rand%0d", n));
        end
        for (int i = 0; i < DMEM; i++) begin
            check($sformatf("rand_mem%0d", i), dut.mydatamem.memory[i], mmem[i]);
        end

        // Abort a lw in its MEM state.
        set_mem(0, 32'hCAFE_0001);
        @(negedge clock);
        instrword = enc_i(6'b100011, 0, 6, 16'd0);
        newinstr  = 1'b1;
        @(negedge clock);
        newinstr = 1'b0;
        repeat (2) @(negedge clock);
        check("abort_in_mem", 32'(dut.r_state), 32'(MEM));
        reset = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
        check("abort_state_idle", 32'(dut.r_state), 32'(IDLE));
        check("abort_r6", dut.myregisterfile.register[6], 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check("abort_r6_later", dut.myregisterfile.register[6], 32'd0);
        check("abort_state_later", 32'(dut.r_state), 32'(IDLE));
        check("abort_mem0", dut.mydatamem.memory[0], 32'hCAFE_0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
